// File: rtl/mem_pkg.sv
//------------------------------------------------------------------------------
// mem_pkg : shared widths and depths for the IM / DM / MEM storage banks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

    localparam int DW        = 32;
    localparam int IM_AW     = 10;
    localparam int DM_AW     = 12;
    localparam int MEM_AW    = 16;

    localparam int IM_DEPTH  = 1024;
    localparam int DM_DEPTH  = 4096;
    localparam int MEM_DEPTH = 65536;

    function automatic int bank_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bank.sv
//------------------------------------------------------------------------------
// mem_bank : one synchronous word-addressed RAM with registered, read-first
//            read port. Idle-read behaviour selected by MEM_OUT_HOLD_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_bank
    import mem_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          read,
    input  logic          write,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int DEPTH = bank_depth(AW);

`ifdef MEM_OUT_HOLD_EN
    localparam bit CLEAR_ON_IDLE = 1'b0;
`else
    localparam bit CLEAR_ON_IDLE = 1'b1;
`endif

    logic [DW-1:0] mem_data [0:DEPTH-1];

    // Storage has no reset; writes are simply suppressed while rst is low.
    always_ff @(posedge clk) begin
        if (rst && enable && write) begin
            mem_data[address] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout <= '0;
        end else if (enable) begin
            if (read) begin
                dout <= mem_data[address];
            end else if (CLEAR_ON_IDLE) begin
                dout <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_subsystem.sv
//------------------------------------------------------------------------------
// mem_subsystem : independent instruction (IM), data (DM) and boot (MEM)
//                 memories on one clock. Option macro: MEM_OUT_HOLD_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_subsystem
    import mem_pkg::*;
#(
    parameter int DW     = mem_pkg::DW,
    parameter int IM_AW  = mem_pkg::IM_AW,
    parameter int DM_AW  = mem_pkg::DM_AW,
    parameter int MEM_AW = mem_pkg::MEM_AW
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              IM_enable,
    input  logic              IM_read,
    input  logic              IM_write,
    input  logic [IM_AW-1:0]  IM_address,
    input  logic [DW-1:0]     IM_in,
    output logic [DW-1:0]     IM_out,

    input  logic              DM_enable,
    input  logic              DM_read,
    input  logic              DM_write,
    input  logic [DM_AW-1:0]  DM_address,
    input  logic [DW-1:0]     DM_in,
    output logic [DW-1:0]     DM_out,

    input  logic              MEM_en,
    input  logic              MEM_read,
    input  logic              MEM_write,
    input  logic [MEM_AW-1:0] MEM_addr,
    input  logic [DW-1:0]     MEM_din,
    output logic [DW-1:0]     MEM_data
);

    mem_bank #(.AW(IM_AW), .DW(DW)) IM1 (
        .clk     (clk),
        .rst     (rst),
        .enable  (IM_enable),
        .read    (IM_read),
        .write   (IM_write),
        .address (IM_address),
        .din     (IM_in),
        .dout    (IM_out)
    );

    mem_bank #(.AW(DM_AW), .DW(DW)) DM1 (
        .clk     (clk),
        .rst     (rst),
        .enable  (DM_enable),
        .read    (DM_read),
        .write   (DM_write),
        .address (DM_address),
        .din     (DM_in),
        .dout    (DM_out)
    );

    mem_bank #(.AW(MEM_AW), .DW(DW)) MEM1 (
        .clk     (clk),
        .rst     (rst),
        .enable  (MEM_en),
        .read    (MEM_read),
        .write   (MEM_write),
        .address (MEM_addr),
        .din     (MEM_din),
        .dout    (MEM_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_subsystem.sv
//------------------------------------------------------------------------------
// tb_mem_subsystem : directed checks of mem_subsystem (reset, read-first,
//                    boot copy, disable/hold, last-address boundaries).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_subsystem;

    logic        clk = 1'b0;
    logic        rst;

    logic        IM_enable, IM_read, IM_write;
    logic [9:0]  IM_address;
    logic [31:0] IM_in, IM_out;

    logic        DM_enable, DM_read, DM_write;
    logic [11:0] DM_address;
    logic [31:0] DM_in, DM_out;

    logic        MEM_en, MEM_read, MEM_write;
    logic [15:0] MEM_addr;
    logic [31:0] MEM_din, MEM_data;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_subsystem dut (
        .clk        (clk),
        .rst        (rst),
        .IM_enable  (IM_enable),
        .IM_read    (IM_read),
        .IM_write   (IM_write),
        .IM_address (IM_address),
        .IM_in      (IM_in),
        .IM_out     (IM_out),
        .DM_enable  (DM_enable),
        .DM_read    (DM_read),
        .DM_write   (DM_write),
        .DM_address (DM_address),
        .DM_in      (DM_in),
        .DM_out     (DM_out),
        .MEM_en     (MEM_en),
        .MEM_read   (MEM_read),
        .MEM_write  (MEM_write),
        .MEM_addr   (MEM_addr),
        .MEM_din    (MEM_din),
        .MEM_data   (MEM_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        {IM_enable, IM_read, IM_write}  = 3'b000;
        {DM_enable, DM_read, DM_write}  = 3'b000;
        {MEM_en, MEM_read, MEM_write}   = 3'b000;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_all();
        IM_address = '0; IM_in  = '0;
        DM_address = '0; DM_in  = '0;
        MEM_addr   = '0; MEM_din = '0;
        tick();
        tick();
        check("reset_idle_IM_out", IM_out, 32'h0);

        // Preload through the write ports.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            MEM_en = 1'b1; MEM_write = 1'b1;
            MEM_addr = 16'(i); MEM_din = 32'(i + 1);
            tick();
        end
        idle_all();
        IM_enable = 1'b1; IM_write = 1'b1; IM_address = 10'd0;  IM_in = 32'hA5A5_A5A5;
        DM_enable = 1'b1; DM_write = 1'b1; DM_address = 12'd3;  DM_in = 32'd5;
        tick();

        // Make every output nonzero before exercising reset.
        idle_all();
        IM_enable = 1'b1; IM_read = 1'b1; IM_address = 10'd0;
        DM_enable = 1'b1; DM_read = 1'b1; DM_address = 12'd3;
        MEM_en    = 1'b1; MEM_read = 1'b1; MEM_addr  = 16'd0;
        tick();
        check("pre_reset_IM_out",  IM_out,   32'hA5A5_A5A5);
        check("pre_reset_DM_out",  DM_out,   32'd5);
        check("pre_reset_MEM_data", MEM_data, 32'd1);

        // Reset with all strobes high: outputs clear, no write lands.
        rst = 1'b0;
        {IM_enable, IM_read, IM_write}  = 3'b111;
        {DM_enable, DM_read, DM_write}  = 3'b111;
        {MEM_en, MEM_read, MEM_write}   = 3'b111;
        IM_in = 32'hFFFF_FFFF; DM_in = 32'hFFFF_FFFF; MEM_din = 32'hFFFF_FFFF;
        tick();
        check("reset_IM_out",   IM_out,   32'h0);
        check("reset_DM_out",   DM_out,   32'h0);
        check("reset_MEM_data", MEM_data, 32'h0);
        check("reset_IM_mem0",  dut.IM1.mem_data[0],  32'hA5A5_A5A5);
        check("reset_DM_mem3",  dut.DM1.mem_data[3],  32'd5);
        check("reset_MEM_mem0", dut.MEM1.mem_data[0], 32'd1);
        rst = 1'b1;
        idle_all();

        // IM write then read.
        IM_enable = 1'b1; IM_write = 1'b1; IM_address = 10'd128; IM_in = 32'hDEAD_BEEF;
        tick();
        IM_write = 1'b0; IM_read = 1'b1;
        tick();
        check("im_write_read", IM_out, 32'hDEAD_BEEF);
        idle_all();

        // DM read-first on same address.
        DM_enable = 1'b1; DM_read = 1'b1; DM_write = 1'b1; DM_address = 12'd3; DM_in = 32'd9;
        tick();
        check("dm_read_first_old", DM_out, 32'd5);
        DM_write = 1'b0;
        tick();
        check("dm_read_after_write", DM_out, 32'd9);
        idle_all();

        // Boot copy MEM[0..3] -> IM[128..131].
        for (int i = 0; i < 4; i++) begin
            idle_all();
            MEM_en = 1'b1; MEM_read = 1'b1; MEM_addr = 16'(i);
            tick();
            idle_all();
            IM_enable = 1'b1; IM_write = 1'b1; IM_address = 10'(128 + i); IM_in = MEM_data;
            tick();
        end
        idle_all();
        check("boot_IM128", dut.IM1.mem_data[128], 32'd1);
        check("boot_IM129", dut.IM1.mem_data[129], 32'd2);
        check("boot_IM130", dut.IM1.mem_data[130], 32'd3);
        check("boot_IM131", dut.IM1.mem_data[131], 32'd4);

        // Disable and hold.
        DM_enable = 1'b1; DM_write = 1'b1; DM_address = 12'd10; DM_in = 32'd7;
        tick();
        DM_write = 1'b0; DM_read = 1'b1;
        tick();
        check("hold_setup_DM_out", DM_out, 32'd7);
        DM_enable = 1'b0; DM_write = 1'b1; DM_read = 1'b1; DM_in = 32'd0;
        tick();
        check("disabled_DM_out", DM_out, 32'd7);
        check("disabled_DM_mem", dut.DM1.mem_data[10], 32'd7);
        DM_enable = 1'b1; DM_write = 1'b0; DM_read = 1'b0;
        tick();
`ifdef MEM_OUT_HOLD_EN
        check("enabled_noread_DM_out", DM_out, 32'd7);
`else
        check("enabled_noread_DM_out", DM_out, 32'd0);
`endif
        idle_all();

        // Boundaries: sentinels next to the last address, then the last address.
        {IM_enable, IM_write} = 2'b11; IM_address = 10'd1022;    IM_in  = 32'hCAFE_0001;
        {DM_enable, DM_write} = 2'b11; DM_address = 12'd4094;    DM_in  = 32'hCAFE_0002;
        {MEM_en, MEM_write}   = 2'b11; MEM_addr   = 16'd65534;   MEM_din = 32'hCAFE_0003;
        tick();
        IM_address = 10'd1023;  IM_in   = 32'h1111_2222;
        DM_address = 12'd4095;  DM_in   = 32'h3333_4444;
        MEM_addr   = 16'd65535; MEM_din = 32'h5555_6666;
        tick();
        {IM_write, IM_read}   = 2'b01;
        {DM_write, DM_read}   = 2'b01;
        {MEM_write, MEM_read} = 2'b01;
        tick();
        idle_all();
        check("bound_IM_out",    IM_out,   32'h1111_2222);
        check("bound_DM_out",    DM_out,   32'h3333_4444);
        check("bound_MEM_data",  MEM_data, 32'h5555_6666);
        check("bound_IM_1022",   dut.IM1.mem_data[1022],   32'hCAFE_0001);
        check("bound_DM_4094",   dut.DM1.mem_data[4094],   32'hCAFE_0002);
        check("bound_MEM_65534", dut.MEM1.mem_data[65534], 32'hCAFE_0003);
        check("bound_IM_0",      dut.IM1.mem_data[0],      32'hA5A5_A5A5);
        check("bound_DM_3",      dut.DM1.mem_data[3],      32'd9);
        check("bound_MEM_0",     dut.MEM1.mem_data[0],     32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
